// File: rtl/cache_mux_types_pkg.sv
// Shared types for the cache-to-memory multiplexing logic.
package cache_mux_types;

    // Arbiter sequencing: one line transaction in flight at a time.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

    // Which cache owned the most recent grant; used for round-robin ties.
    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/p_cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// One transaction in flight; address/data are latched at grant time and the
// memory response is routed only to the cache that owns the grant.
module p_cache_arbiter
    import cache_mux_types::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [s_line-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [s_line-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [s_line-1:0] pmem_rdata
);

    arb_state_t        state;
    arb_state_t        state_next;
    arb_grant_t        last_grant;
    arb_grant_t        grant_next;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;

    logic              latch_en;
    logic              latch_wdata;
    logic [s_addr-1:0] latch_addr;
    logic              i_req;
    logic              d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Next state and grant selection; ties go to the cache not granted last.
    always_comb begin
        state_next  = state;
        grant_next  = last_grant;
        latch_en    = 1'b0;
        latch_wdata = 1'b0;
        latch_addr  = i_pmem_address;
        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || last_grant == ARB_I)) begin
                    // A simultaneous read and write from the D-cache is a write-back.
                    state_next  = d_pmem_write ? D_WRITE : D_READ;
                    grant_next  = ARB_D;
                    latch_en    = 1'b1;
                    latch_wdata = d_pmem_write;
                    latch_addr  = d_pmem_address;
                end else if (i_req) begin
                    state_next = I_READ;
                    grant_next = ARB_I;
                    latch_en   = 1'b1;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (pmem_resp) begin
                    state_next = DONE;
                end
            end
            // Dead cycle lets the served cache drop its request before re-arbitration.
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, round-robin history and the latched transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= ARB_I;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_next;
            last_grant <= grant_next;
            if (latch_en) begin
                addr_q <= latch_addr;
            end
            if (latch_wdata) begin
                wdata_q <= d_pmem_wdata;
            end
        end
    end

    // Output decode: strobes only in grant states, response gated by owner.
    always_comb begin
        pmem_read    = (state == I_READ) || (state == D_READ);
        pmem_write   = (state == D_WRITE);
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_pmem_resp  = pmem_resp && (state == I_READ);
        d_pmem_resp  = pmem_resp && ((state == D_READ) || (state == D_WRITE));
        i_pmem_rdata = pmem_rdata;
        d_pmem_rdata = pmem_rdata;
    end

endmodule

// File: tb/tb_p_cache_arbiter.sv
// Self-checking bench for p_cache_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_p_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [255:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    int tests = 0;
    int fails = 0;

    p_cache_arbiter #(.s_line(256), .s_addr(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Memory side of one granted transaction. Call during the IDLE cycle in
    // which the request is driven; returns what was observed on both sides,
    // ending after the dead cycle that follows the response.
    task automatic mem_txn(input int lat, input logic [255:0] line,
                           output logic st_read, output logic st_write,
                           output logic [31:0] st_addr, output logic [255:0] st_wdata,
                           output bit stable, output int iresp_cnt, output int dresp_cnt,
                           output logic [255:0] rdata_i, output logic [255:0] rdata_d,
                           output bit done_strobe);
        stable = 1'b1;
        iresp_cnt = 0;
        dresp_cnt = 0;
        st_read = 1'b0; st_write = 1'b0; st_addr = '0; st_wdata = '0;
        rdata_i = '0; rdata_d = '0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            pmem_resp  = (k == lat);
            pmem_rdata = line;
            #1;
            if (k == 1) begin
                st_read = pmem_read; st_write = pmem_write;
                st_addr = pmem_address; st_wdata = pmem_wdata;
            end else if (pmem_read !== st_read || pmem_write !== st_write ||
                         pmem_address !== st_addr || pmem_wdata !== st_wdata) begin
                stable = 1'b0;
            end
            if (i_pmem_resp) iresp_cnt++;
            if (d_pmem_resp) dresp_cnt++;
            if (k == lat) begin
                rdata_i = i_pmem_rdata;
                rdata_d = d_pmem_rdata;
            end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        done_strobe = pmem_read | pmem_write;
        if (i_pmem_resp) iresp_cnt++;
        if (d_pmem_resp) dresp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        i_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        pmem_resp = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes: got %b, want 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        end
        tests++;
        if (pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
            fails++;
            $display("FAIL reset_latches: addr %h wdata %h, want 0", pmem_address, pmem_wdata);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_i_read_alone();
        logic r, w; logic [31:0] a; logic [255:0] wd, ri, rd; bit st, ds; int ic, dc;
        @(negedge clk);
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0040;
        mem_txn(4, {32{8'hA5}}, r, w, a, wd, st, ic, dc, ri, rd, ds);
        tests++;
        if (r !== 1'b1 || w !== 1'b0 || a !== 32'h40) begin
            fails++;
            $display("FAIL i_read_strobe: read %b write %b addr %h, want 1 0 00000040", r, w, a);
        end
        tests++;
        if (!st) begin fails++; $display("FAIL i_read_hold: strobe not stable, want stable"); end
        tests++;
        if (ic !== 1 || dc !== 0) begin
            fails++;
            $display("FAIL i_read_resp: i_resp %0d d_resp %0d, want 1 0", ic, dc);
        end
        tests++;
        if (ri !== {32{8'hA5}}) begin fails++; $display("FAIL i_read_data: got %h, want A5 line", ri); end
        tests++;
        if (ds) begin fails++; $display("FAIL i_read_done: strobe %b in dead cycle, want 0", ds); end
        @(negedge clk);
        i_pmem_read = 1'b0;
        #1;
        tests++;
        if (pmem_read !== 1'b0) begin fails++; $display("FAIL i_read_idle: pmem_read %b, want 0", pmem_read); end
    endtask

    task automatic test_tie_d_first();
        logic r, w; logic [31:0] a; logic [255:0] wd, ri, rd; bit st, ds; int ic, dc;
        apply_reset();
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        mem_txn(2, {8{32'h1111_2222}}, r, w, a, wd, st, ic, dc, ri, rd, ds);
        tests++;
        if (r !== 1'b1 || a !== 32'h200 || dc !== 1 || ic !== 0 || rd !== {8{32'h1111_2222}}) begin
            fails++;
            $display("FAIL tie_first: read %b addr %h d_resp %0d i_resp %0d, want 1 00000200 1 0", r, a, dc, ic);
        end
        @(negedge clk);
        d_pmem_read = 1'b0;
        #1;
        tests++;
        if (pmem_read !== 1'b0 || ds) begin
            fails++;
            $display("FAIL tie_gap: strobe %b/%b in gap cycles, want 0/0", ds, pmem_read);
        end
        mem_txn(3, {8{32'h3333_4444}}, r, w, a, wd, st, ic, dc, ri, rd, ds);
        tests++;
        if (r !== 1'b1 || a !== 32'h100 || ic !== 1 || dc !== 0 || ri !== {8{32'h3333_4444}}) begin
            fails++;
            $display("FAIL tie_second: read %b addr %h i_resp %0d d_resp %0d, want 1 00000100 1 0", r, a, ic, dc);
        end
        @(negedge clk);
        i_pmem_read = 1'b0;
    endtask

    task automatic test_write_wins();
        logic r, w; logic [31:0] a; logic [255:0] wd, ri, rd; bit st, ds; int ic, dc;
        logic [255:0] pat;
        pat = {4{64'hDEAD_0123_4567_BEEF}};
        @(negedge clk);
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'h300; d_pmem_wdata = pat;
        mem_txn(3, '0, r, w, a, wd, st, ic, dc, ri, rd, ds);
        tests++;
        if (w !== 1'b1 || r !== 1'b0 || a !== 32'h300 || wd !== pat) begin
            fails++;
            $display("FAIL write_wins: write %b read %b addr %h wdata %h, want 1 0 00000300 %h", w, r, a, wd, pat);
        end
        tests++;
        if (dc !== 1 || ic !== 0 || !st) begin
            fails++;
            $display("FAIL write_resp: d_resp %0d i_resp %0d stable %b, want 1 0 1", dc, ic, st);
        end
        @(negedge clk);
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    endtask

    task automatic test_addr_change();
        int bad;
        int dcnt;
        bad = 0;
        dcnt = 0;
        @(negedge clk);
        d_pmem_read = 1'b1; d_pmem_address = 32'h400;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            d_pmem_address = 32'h480;
            d_pmem_wdata = {8{$urandom}};
            pmem_resp = (k == 3);
            #1;
            if (pmem_address !== 32'h400 || pmem_read !== 1'b1) bad++;
            if (d_pmem_resp) dcnt++;
        end
        tests++;
        if (bad != 0 || dcnt != 1) begin
            fails++;
            $display("FAIL addr_change: %0d cycles off 0x400, d_resp %0d, want 0 1 (addr now %h)", bad, dcnt, pmem_address);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        d_pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic r, w; logic [31:0] a; logic [255:0] wd, ri, rd; bit st, ds; int ic, dc;
        bit exp_d;
        apply_reset();
        @(negedge clk);
        i_pmem_read = 1'b1; i_pmem_address = 32'h600;
        d_pmem_read = 1'b1; d_pmem_address = 32'h500;
        for (int t = 0; t < 6; t++) begin
            exp_d = (t % 2 == 0);
            mem_txn(1 + t % 3, {8{$urandom}}, r, w, a, wd, st, ic, dc, ri, rd, ds);
            tests++;
            if (a !== (exp_d ? 32'h500 : 32'h600) || ic !== (exp_d ? 0 : 1) || dc !== (exp_d ? 1 : 0) || ds) begin
                fails++;
                $display("FAIL alternate_%0d: addr %h i_resp %0d d_resp %0d dead_strobe %b, want %h %0d %0d 0",
                         t, a, ic, dc, ds, exp_d ? 32'h500 : 32'h600, exp_d ? 0 : 1, exp_d ? 1 : 0);
            end
            @(negedge clk);
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        d_pmem_write = 1'b1; d_pmem_address = 32'h700; d_pmem_wdata = {8{32'hCAFE_F00D}};
        @(negedge clk);
        #1;
        tests++;
        if (pmem_write !== 1'b1) begin fails++; $display("FAIL reset_mid_pre: pmem_write %b, want 1", pmem_write); end
        rst = 1'b0;
        #1;
        tests++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_drop: write %b read %b addr %h, want 0 0 00000000", pmem_write, pmem_read, pmem_address);
        end
        @(negedge clk);
        rst = 1'b1;
        d_pmem_write = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        tests++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0 || pmem_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_resp: i_resp %b d_resp %b write %b, want 0 0 0", i_pmem_resp, d_pmem_resp, pmem_write);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: the model only
    // knows who is served, with what, and when the port frees up again.
    task automatic test_random();
        bit ir, dr, dw, i_served, d_served, resp;
        logic [31:0] ia, da, m_addr;
        logic [255:0] dwd, m_wdata, line;
        bit m_active, m_wr;
        int m_who, m_last, m_free_at, m_start, m_lat, kind, err;
        apply_reset();
        ir = 0; dr = 0; dw = 0; i_served = 0; d_served = 0;
        ia = '0; da = '0; dwd = '0;
        m_active = 0; m_wr = 0; m_who = 0; m_last = 0; m_free_at = 0; m_start = 0; m_lat = 1;
        m_addr = '0; m_wdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (i_served) begin
                ir = 0; i_served = 0;
            end else if (!ir && $urandom_range(0, 2) == 0) begin
                ir = 1; ia = $urandom & ~32'h1F;
            end else if (ir && $urandom_range(0, 5) == 0) begin
                ia = $urandom & ~32'h1F;
            end
            if (d_served) begin
                dr = 0; dw = 0; d_served = 0;
            end else if (!(dr || dw) && $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 2);
                dr = (kind != 1); dw = (kind != 0);
                da = $urandom & ~32'h1F;
                for (int j = 0; j < 8; j++) dwd[j*32 +: 32] = $urandom;
            end else if ((dr || dw) && $urandom_range(0, 5) == 0) begin
                da = $urandom & ~32'h1F;
                dwd[31:0] = $urandom;
            end
            for (int j = 0; j < 8; j++) line[j*32 +: 32] = $urandom;
            resp = m_active ? (cyc == m_start + m_lat) : ($urandom_range(0, 7) == 0);
            i_pmem_read = ir; i_pmem_address = ia;
            d_pmem_read = dr; d_pmem_write = dw; d_pmem_address = da; d_pmem_wdata = dwd;
            pmem_resp = resp; pmem_rdata = line;
            #1;
            err = 0;
            if (pmem_read !== (m_active && !m_wr)) err |= 1;
            if (pmem_write !== (m_active && m_wr)) err |= 2;
            if (m_active && pmem_address !== m_addr) err |= 4;
            if (m_active && m_wr && pmem_wdata !== m_wdata) err |= 8;
            if (i_pmem_resp !== (resp && m_active && m_who == 0)) err |= 16;
            if (d_pmem_resp !== (resp && m_active && m_who == 1)) err |= 32;
            if (resp && m_active && ((m_who == 0 && i_pmem_rdata !== line) || (m_who == 1 && d_pmem_rdata !== line))) err |= 64;
            tests++;
            if (err != 0) begin
                fails++;
                $display("FAIL random_cyc%0d: err %b rd %b wr %b addr %h iresp %b dresp %b, want rd %b wr %b addr %h who %0d resp %b",
                         cyc, err[6:0], pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp,
                         m_active && !m_wr, m_active && m_wr, m_addr, m_who, resp);
            end
            if (m_active) begin
                if (resp) begin
                    if (m_who == 0) i_served = 1; else d_served = 1;
                    m_active = 0;
                    m_free_at = cyc + 2;
                end
            end else if (cyc >= m_free_at && (ir || dr || dw)) begin
                m_who = ((dr || dw) && (!ir || m_last == 0)) ? 1 : 0;
                m_active = 1;
                m_wr = (m_who == 1) && dw;
                m_addr = (m_who == 1) ? da : ia;
                if (m_wr) m_wdata = dwd;
                m_last = m_who;
                m_start = cyc;
                m_lat = $urandom_range(1, 4);
            end
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_i_read_alone();
        test_tie_d_first();
        test_write_wins();
        test_addr_change();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/p_cache_arbiter.md
# p_cache_arbiter

Shares the single 256-bit physical-memory port between the pipelined I-cache and D-cache. Sits between the two caches' `pmem_*` ports and the cacheline adaptor / main memory. Accepts one outstanding line transaction at a time, latches its address and data, and forwards the memory response to the granted cache only. Arbitration is round-robin when both caches request in the same cycle.

## Interface
Parameters:
- `s_line`, 256, cache line width in bits.
- `s_addr`, 32, address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_pmem_read`  in  1  I-cache line read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  32  I-cache line address.
- `i_pmem_resp`  out  1  I-cache response pulse.
- `i_pmem_rdata`  out  256  I-cache read line.
- `d_pmem_read`  in  1  D-cache line read request; held until `d_pmem_resp`.
- `d_pmem_write`  in  1  D-cache line write-back request; held until `d_pmem_resp`.
- `d_pmem_address`  in  32  D-cache line address.
- `d_pmem_wdata`  in  256  D-cache write-back line.
- `d_pmem_resp`  out  1  D-cache response pulse.
- `d_pmem_rdata`  out  256  D-cache read line.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  32  memory address; latched.
- `pmem_wdata`  out  256  memory write data; latched.
- `pmem_resp`  in  1  memory completion pulse.
- `pmem_rdata`  in  256  memory read line.

## Operation
- States: `IDLE`, `I_READ`, `D_READ`, `D_WRITE`, `DONE`.
- `IDLE`: sample requests.
  - Only the I-cache requests: go to `I_READ`.
  - Only the D-cache requests: go to `D_READ` or `D_WRITE`.
  - Both request: grant the cache not named by `last_grant`; after reset `last_grant = I`, so the D-cache wins the first tie.
  - On grant: latch the address into `addr_q` (and `d_pmem_wdata` into `wdata_q` for writes); update `last_grant`.
- D-cache `read` and `write` asserted together: the write wins.
- Grant states:
  - Drive `pmem_read` (`I_READ`, `D_READ`) or `pmem_write` (`D_WRITE`) high from `addr_q` / `wdata_q`.
  - Hold the strobe until `pmem_resp`, then go to `DONE`.
- Response: `x_pmem_resp = pmem_resp` gated by the owning state. `pmem_rdata` goes combinationally to both `x_pmem_rdata` and is meaningful only with resp.
- `DONE`: one dead cycle with no strobes and no resp, then `IDLE`. This gives the served cache time to drop its request, so it is not re-granted.
- Request changes or drops while granted are ignored; the latched values are used until completion.
- Reset asserted mid-transaction:
  - Immediately return to `IDLE`; all strobes and resps go to 0.
  - The in-flight memory response is lost; memory must also be reset.

## Timing
- Reset values: state `IDLE`, `last_grant = I`, `addr_q = 0`, `wdata_q = 0`. All `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` are 0. `pmem_address = 0`, `pmem_wdata = 0`.
- Request seen in cycle N (`IDLE`) puts the strobe on the memory in cycle N+1.
- `pmem_resp` in cycle M produces `x_pmem_resp` in cycle M (zero added latency), `DONE` in M+1, and `IDLE` in M+2.
- Earliest next grant is sampled in M+2, so the strobe appears in M+3.
- Minimum overhead is 2 cycles per transaction beyond memory latency.
- `pmem_resp` outside a grant state is ignored.
- The strobe is never asserted in `IDLE` or `DONE`.

## Structure
- Add `arb_state_t` (`IDLE`, `I_READ`, `D_READ`, `D_WRITE`, `DONE`) and `arb_grant_t` (`ARB_I`, `ARB_D`) to the shared `cache_mux_types` package.
- Single module, with no sub-module.
  - One `always_ff` for state and latches.
  - One `always_comb` each for next-state/grant and for output decode.

## Test plan
- Reset, then I-cache read of `0x0000_0040` alone → `pmem_read=1`, `pmem_address=0x40` next cycle. Memory returns line `0xA5…A5` after 4 cycles → `i_pmem_resp` pulses 1 cycle with that data. `d_pmem_resp` stays 0.
- I read `0x100` and D read `0x200` in the same cycle after reset → D served first (`pmem_address=0x200`), then I (`0x100`), with exactly one dead cycle between.
- D-cache asserts read and write together, address `0x300`, wdata `0xDEAD…BEEF` → `pmem_write=1`, `pmem_wdata` matches, `pmem_read=0`.
- D changes its address from `0x400` to `0x480` while in `D_READ` → `pmem_address` stays `0x400` until resp.
- Both caches request continuously for 6 transactions → grants alternate D, I, D, I, D, I. Neither resp is ever asserted twice for one request.
- Reset pulled low for 1 cycle during `D_WRITE` → strobes drop immediately and state is `IDLE`. A later `pmem_resp` pulse produces no cache resp.
